// File: rtl/load_use_hazard_unit_if.sv
// load_use_hazard_unit_if
//   Bundle between the pipeline control path and the load-use hazard unit.
//   master : pipeline side, drives ID/EX instruction info, receives stall/flush.
//   slave  : hazard unit side.
//   Signals:
//     opcode_id, rs1_id, rs2_id        instruction currently in ID
//     mem_read_ex, rd_ex               load flag and destination of EX instruction
//     branch_taken_ex                  EX resolved a taken branch/jump
//     stall_pc, stall_if_id            hold PC / IF/ID
//     bubble_id_ex                     insert NOP into ID/EX
//     flush_if_id, flush_id_ex         squash IF/ID and ID/EX
//     stall_count, flush_count         saturating performance counters
interface load_use_hazard_unit_if #(
    parameter int CNT_W = 16
);
    logic [6:0]       opcode_id;
    logic [4:0]       rs1_id;
    logic [4:0]       rs2_id;
    logic             mem_read_ex;
    logic [4:0]       rd_ex;
    logic             branch_taken_ex;
    logic             stall_pc;
    logic             stall_if_id;
    logic             bubble_id_ex;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output opcode_id, rs1_id, rs2_id, mem_read_ex, rd_ex, branch_taken_ex,
        input  stall_pc, stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex,
               stall_count, flush_count
    );

    modport slave (
        input  opcode_id, rs1_id, rs2_id, mem_read_ex, rd_ex, branch_taken_ex,
        output stall_pc, stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex,
               stall_count, flush_count
    );
endinterface

// File: rtl/load_use_hazard_unit.sv
// load_use_hazard_unit
//   Stall/flush controller at the ID/EX boundary. Stalls PC and IF/ID and
//   bubbles ID/EX when a load in EX writes a register the ID instruction
//   reads, for LOAD_STALL_CYCLES cycles. A taken branch in EX squashes
//   IF/ID and ID/EX and overrides any stall. Counts stall and flush cycles
//   in saturating counters.
//   Ports:
//     clk   clock, rising edge
//     rst   asynchronous, active-high reset
//     hz    load_use_hazard_unit_if.slave (instruction info in, stall/flush out)
module load_use_hazard_unit #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    load_use_hazard_unit_if.slave   hz
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_B      = 7'b1100011;

    localparam int RW = $clog2(LOAD_STALL_CYCLES + 1);
    localparam logic [RW-1:0] REMAIN_INIT = RW'(LOAD_STALL_CYCLES - 1);
    localparam logic [RW-1:0] REMAIN_ONE  = RW'(1);

    typedef enum logic {
        IDLE,
        STALL
    } state_t;

    state_t        state, next_state;
    logic [RW-1:0] remain, next_remain;
    logic          uses_rs1, uses_rs2;
    logic          hazard;
    logic          stall_c, flush_c;
    logic          stall_o, flush_o;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    // Source-register usage by opcode class; U, J and unknown read nothing.
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (hz.opcode_id)
            OP_R, OP_S, OP_B: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_I_ALU, OP_LOAD, OP_JALR: uses_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign hazard = hz.mem_read_ex && (hz.rd_ex != '0) &&
                    ((uses_rs1 && (hz.rd_ex == hz.rs1_id)) ||
                     (uses_rs2 && (hz.rd_ex == hz.rs2_id)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            remain <= '0;
        end else begin
            state  <= next_state;
            remain <= next_remain;
        end
    end

    always_comb begin
        next_state  = state;
        next_remain = remain;
        stall_c     = 1'b0;
        flush_c     = 1'b0;
        if (hz.branch_taken_ex) begin
            // Flush wins over any stall, including one already in progress.
            flush_c     = 1'b1;
            next_state  = IDLE;
            next_remain = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hazard) begin
                        stall_c = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            next_state  = STALL;
                            next_remain = REMAIN_INIT;
                        end
                    end
                end
                STALL: begin
                    stall_c = 1'b1;
                    if (remain == REMAIN_ONE) begin
                        next_state  = IDLE;
                        next_remain = '0;
                    end else begin
                        next_remain = remain - 1'b1;
                    end
                end
                default: begin
                    next_state  = IDLE;
                    next_remain = '0;
                end
            endcase
        end
    end

    // Outputs are held low combinationally while reset is asserted.
    assign stall_o = stall_c & ~rst;
    assign flush_o = flush_c & ~rst;

    assign hz.stall_pc     = stall_o;
    assign hz.stall_if_id  = stall_o;
    assign hz.bubble_id_ex = stall_o;
    assign hz.flush_if_id  = flush_o;
    assign hz.flush_id_ex  = flush_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_o && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (flush_o && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign hz.stall_count = stall_cnt;
    assign hz.flush_count = flush_cnt;

endmodule
